// File: rtl/instr_queue.sv
// ---------------------------------------------------------------------------
// instr_queue -- consumer end of the fetch interface.
//
// Buffers {instr, pc} pairs from fetch in a circular FIFO and presents them,
// in order, to decode/rename through a valid/ready handshake. The all-zero
// instruction is the end-of-trace marker: it is swallowed (never enqueued),
// closes the input side, and trace_done rises once the queue has drained.
//
// Optional feature macro: IQ_BYPASS_EN
//   defined   -> an arriving pair is handed straight to the output in the same
//                cycle when the queue is empty and decode is ready.
//   undefined -> no input-to-output combinational path (minimum latency one
//                cycle).
//
// Ports:
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset
//   in_valid   fetch presents a valid pair
//   in_instr   fetched instruction
//   in_pc      PC of in_instr
//   in_ready   queue accepts a pair this cycle (fetch PC write enable)
//   out_valid  head entry valid
//   out_instr  head instruction (0 when empty)
//   out_pc     head PC (0 when empty)
//   out_ready  decode consumes the head this cycle
//   flush      synchronous discard of all contents, highest priority
//   count      number of occupied entries
//   trace_done end-of-trace marker seen and queue empty
// ---------------------------------------------------------------------------
module instr_queue #(
    parameter int DEPTH   = 8,
    parameter int INSTR_W = 32,
    parameter int PC_W    = 12
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     in_valid,
    input  logic [INSTR_W-1:0]       in_instr,
    input  logic [PC_W-1:0]          in_pc,
    output logic                     in_ready,
    output logic                     out_valid,
    output logic [INSTR_W-1:0]       out_instr,
    output logic [PC_W-1:0]          out_pc,
    input  logic                     out_ready,
    input  logic                     flush,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     trace_done
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE  = {{AW{1'b0}}, 1'b1};
    localparam logic [AW:0] PTR_ZERO = {(AW+1){1'b0}};

    // Pointers carry an extra wrap bit so full and empty are distinguishable.
    logic [AW:0]        wptr_r;
    logic [AW:0]        rptr_r;
    logic [AW:0]        count_r;
    logic               eot_seen_r;

    logic [INSTR_W-1:0] mem_instr [0:DEPTH-1];
    logic [PC_W-1:0]    mem_pc    [0:DEPTH-1];

    logic               empty_s;
    logic               full_s;
    logic               accept_s;
    logic               is_marker_s;
    logic               bypass_s;
    logic               push_s;
    logic               pop_s;

    assign empty_s     = (wptr_r == rptr_r);
    assign full_s      = (wptr_r[AW-1:0] == rptr_r[AW-1:0]) && (wptr_r[AW] != rptr_r[AW]);
    assign in_ready    = !full_s && !eot_seen_r;
    assign accept_s    = in_valid && in_ready;
    assign is_marker_s = (in_instr == {INSTR_W{1'b0}});

`ifdef IQ_BYPASS_EN
    // Empty queue with decode ready: the pair flows through without storage.
    assign bypass_s = empty_s && accept_s && !is_marker_s && out_ready && !flush;
`else
    assign bypass_s = 1'b0;
`endif

    assign push_s     = accept_s && !is_marker_s && !bypass_s;
    assign pop_s      = !empty_s && out_ready;
    assign out_valid  = !empty_s || bypass_s;
    assign count      = count_r;
    assign trace_done = eot_seen_r && empty_s;

    // Head selection: bypass pair, stored head, or zero when nothing to show.
    always_comb begin
        out_instr = {INSTR_W{1'b0}};
        out_pc    = {PC_W{1'b0}};
        if (bypass_s) begin
            out_instr = in_instr;
            out_pc    = in_pc;
        end else if (!empty_s) begin
            out_instr = mem_instr[rptr_r[AW-1:0]];
            out_pc    = mem_pc[rptr_r[AW-1:0]];
        end else begin
            out_instr = {INSTR_W{1'b0}};
            out_pc    = {PC_W{1'b0}};
        end
    end

    // Storage array write; intentionally not reset, flush only moves pointers.
    always_ff @(posedge clk) begin
        if (push_s && !flush) begin
            mem_instr[wptr_r[AW-1:0]] <= in_instr;
            mem_pc[wptr_r[AW-1:0]]    <= in_pc;
        end
    end

    // Pointer, occupancy and end-of-trace state; flush overrides all traffic.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wptr_r     <= PTR_ZERO;
            rptr_r     <= PTR_ZERO;
            count_r    <= PTR_ZERO;
            eot_seen_r <= 1'b0;
        end else if (flush) begin
            wptr_r     <= PTR_ZERO;
            rptr_r     <= PTR_ZERO;
            count_r    <= PTR_ZERO;
            eot_seen_r <= 1'b0;
        end else begin
            if (push_s) begin
                wptr_r <= wptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rptr_r <= rptr_r + PTR_ONE;
            end
            if (accept_s && is_marker_s) begin
                eot_seen_r <= 1'b1;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + PTR_ONE;
                2'b01:   count_r <= count_r - PTR_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_queue.sv
// ---------------------------------------------------------------------------
// tb_instr_queue -- scoreboard bench for instr_queue.
// The stimulus process pushes each expected {instr, pc} into a queue when it
// issues the pair; an independent monitor pops and compares on every cycle in
// which the DUT hands an entry to decode. State checks (count, in_ready,
// trace_done, ...) use hand-computed constants.
// ---------------------------------------------------------------------------
module tb_instr_queue;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic [31:0] in_instr;
    logic [11:0] in_pc;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [11:0] out_pc;
    logic        out_ready;
    logic        flush;
    logic [3:0]  count;
    logic        trace_done;

    int checks = 0;
    int errors = 0;
    int max_count = 0;
    logic [43:0] sb [$];

    instr_queue #(.DEPTH(8), .INSTR_W(32), .PC_W(12)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_instr   (in_instr),
        .in_pc      (in_pc),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_instr  (out_instr),
        .out_pc     (out_pc),
        .out_ready  (out_ready),
        .flush      (flush),
        .count      (count),
        .trace_done (trace_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one pair; expected entry recorded at issue time (marker excluded).
    task automatic send(input logic [31:0] instr, input logic [11:0] pc);
        bit ok = 1'b0;
        if (instr != 32'h0) sb.push_back({instr, pc});
        in_valid = 1'b1;
        in_instr = instr;
        in_pc    = pc;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got in_ready 0 expected 1 (pc %0h)", pc);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_instr = 32'h0;
        in_pc    = 12'h0;
    endtask

    // Wait (bounded) for the queue to become empty.
    task automatic wait_empty(input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (count == 4'd0 && !out_valid) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        check(name, {63'd0, ok}, 64'd1);
    endtask

    // Monitor: compare every consumed head against the scoreboard.
    always @(negedge clk) begin
        if (reset_n) begin
            if (int'(count) > max_count) max_count = int'(count);
            if (out_valid && out_ready && !flush) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got %0h@%0h expected none", out_instr, out_pc);
                end else begin
                    logic [43:0] e;
                    e = sb.pop_front();
                    check("out_instr", {32'd0, out_instr}, {32'd0, e[43:12]});
                    check("out_pc", {52'd0, out_pc}, {52'd0, e[11:0]});
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_instr  = 32'h0;
        in_pc     = 12'h0;
        out_ready = 1'b0;
        flush     = 1'b0;
        #12;
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);
        check("rst_trace_done", {63'd0, trace_done}, 64'd0);
        check("rst_out_instr", {32'd0, out_instr}, 64'd0);
        check("rst_out_pc", {52'd0, out_pc}, 64'd0);
        check("rst_count", {60'd0, count}, 64'd0);
        reset_n = 1'b1;
        tick();

        // 1: three pairs streamed with decode ready
        out_ready = 1'b1;
        send(32'h00500093, 12'h000);
        send(32'h00A00113, 12'h004);
        send(32'h002081B3, 12'h008);
        wait_empty("t1_drain");
        check("t1_count", {60'd0, count}, 64'd0);
        check("t1_out_valid", {63'd0, out_valid}, 64'd0);

        // 2: fill to 8, refuse a 9th, single pop
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++)
            send(32'h00000013 | (32'(i + 1) << 7), 12'h100 + 12'(4 * i));
        check("t2_count_full", {60'd0, count}, 64'd8);
        check("t2_in_ready_full", {63'd0, in_ready}, 64'd0);
        in_valid = 1'b1;
        in_instr = 32'h12345013;
        in_pc    = 12'h200;
        tick();
        tick();
        check("t2_ninth_refused", {60'd0, count}, 64'd8);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("t2_count_pop", {60'd0, count}, 64'd7);
        check("t2_head_pc", {52'd0, out_pc}, 64'h104);
        check("t2_in_ready_after_pop", {63'd0, in_ready}, 64'd1);
        out_ready = 1'b1;
        wait_empty("t2_drain");

        // 3: twelve pairs across pointer wrap with toggling out_ready
        max_count = 0;
        out_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 12; i++)
                    send(32'h00001033 + (32'(i) << 15), 12'h300 + 12'(4 * i));
            end
            begin
                for (int k = 0; k < 30; k++) begin
                    tick();
                    out_ready = ~out_ready;
                end
            end
        join
        out_ready = 1'b1;
        wait_empty("t3_drain");
        check("t3_max_count", {63'd0, max_count <= 8}, 64'd1);
        check("t3_sb_empty", 64'(sb.size()), 64'd0);

        // 4: end-of-trace marker then drain
        out_ready = 1'b0;
        send(32'h00100093, 12'h400);
        send(32'h00200113, 12'h404);
        send(32'h00000000, 12'h408);
        check("t4_in_ready_eot", {63'd0, in_ready}, 64'd0);
        check("t4_count_eot", {60'd0, count}, 64'd2);
        check("t4_trace_done_early", {63'd0, trace_done}, 64'd0);
        out_ready = 1'b1;
        tick();
        check("t4_count_one", {60'd0, count}, 64'd1);
        check("t4_trace_done_mid", {63'd0, trace_done}, 64'd0);
        tick();
        check("t4_trace_done", {63'd0, trace_done}, 64'd1);
        check("t4_in_ready_drained", {63'd0, in_ready}, 64'd0);
        out_ready = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("t4_in_ready_flush", {63'd0, in_ready}, 64'd1);
        check("t4_trace_done_flush", {63'd0, trace_done}, 64'd0);

        // 5: flush with concurrent push and pop
        for (int i = 0; i < 5; i++)
            send(32'h00700713 + (32'(i) << 20), 12'h500 + 12'(4 * i));
        check("t5_count_five", {60'd0, count}, 64'd5);
        flush     = 1'b1;
        in_valid  = 1'b1;
        in_instr  = 32'h00900913;
        in_pc     = 12'h600;
        out_ready = 1'b1;
        sb.delete();
        tick();
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("t5_count", {60'd0, count}, 64'd0);
        check("t5_out_valid", {63'd0, out_valid}, 64'd0);
        check("t5_in_ready", {63'd0, in_ready}, 64'd1);
        tick();
        check("t5_nothing_pushed", {60'd0, count}, 64'd0);

        // 6: latency from empty queue with decode ready
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_instr  = 32'h00500093;
        in_pc     = 12'h020;
        sb.push_back({32'h00500093, 12'h020});
        #2;
`ifdef IQ_BYPASS_EN
        check("t6_bypass_valid", {63'd0, out_valid}, 64'd1);
        check("t6_bypass_instr", {32'd0, out_instr}, 64'h00500093);
        tick();
        in_valid = 1'b0;
        check("t6_bypass_count", {60'd0, count}, 64'd0);
`else
        check("t6_same_cycle_valid", {63'd0, out_valid}, 64'd0);
        tick();
        in_valid = 1'b0;
        check("t6_next_cycle_valid", {63'd0, out_valid}, 64'd1);
        check("t6_count", {60'd0, count}, 64'd1);
`endif
        wait_empty("t6_drain");

        // 7: asynchronous reset mid-operation
        out_ready = 1'b0;
        send(32'h00B00593, 12'h700);
        send(32'h00C00613, 12'h704);
        #2;
        reset_n = 1'b0;
        sb.delete();
        #1;
        check("t7_count_rst", {60'd0, count}, 64'd0);
        check("t7_out_valid_rst", {63'd0, out_valid}, 64'd0);
        check("t7_out_instr_rst", {32'd0, out_instr}, 64'd0);
        tick();
        reset_n = 1'b1;
        tick();
        check("t7_in_ready", {63'd0, in_ready}, 64'd1);

        check("final_sb_empty", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_queue.md
Name: instr_queue

Overview:
- Consumer end of the fetch interface. Accepts {instr, pc} pairs from the fetch stage and buffers them in a circular FIFO.
- Presents the buffered pairs in order to decode/rename through a valid/ready handshake.
- Back-pressures fetch through in_ready, which fetch uses as its PC write enable.
- Recognises the all-zero instruction as the end-of-trace marker and reports trace drain completion to the testbench.

Parameters:
- DEPTH, 8, number of entries; must be a power of two and at least 2.
- INSTR_W, 32, instruction width.
- PC_W, 12, PC width; matches the 4 KB byte-addressed instruction ROM.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous active-low reset.
- in_valid  input  1  fetch presents a valid instr/pc pair.
- in_instr  input  INSTR_W  fetched instruction.
- in_pc  input  PC_W  PC of in_instr.
- in_ready  output  1  queue accepts a pair this cycle; fetch stalls its PC when low.
- out_valid  output  1  head entry is valid.
- out_instr  output  INSTR_W  head instruction.
- out_pc  output  PC_W  head PC.
- out_ready  input  1  decode consumes the head this cycle.
- flush  input  1  synchronous discard of all contents (mispredict/recovery).
- count  output  $clog2(DEPTH)+1  number of occupied entries.
- trace_done  output  1  end-of-trace marker seen and queue empty.

Behaviour:
- Reset (reset_n low, asynchronous):
  - wptr, rptr and count go to 0; eot_seen goes to 0.
  - Resulting outputs: out_valid=0, in_ready=1, trace_done=0, out_instr=0, out_pc=0.
  - Storage array is not reset.
- Pointers are $clog2(DEPTH)+1 bits, the MSB being a wrap bit.
  - empty = (wptr==rptr).
  - full = index bits equal and wrap bits differ.
  - Pointers wrap naturally modulo 2*DEPTH.
- in_ready = !full && !eot_seen.
- push = in_valid && in_ready && (in_instr != 0). On push, the pair is written at wptr[idx] and wptr increments.
- End-of-trace: in_valid && in_ready && (in_instr == 0) sets eot_seen at the clock edge.
  - The marker is not enqueued and is not counted.
  - From then on in_ready=0 until reset or flush.
- out_valid = !empty. out_instr/out_pc = mem[rptr[idx]], first-word fall-through. When empty, out_instr/out_pc are forced to 0.
- pop = out_valid && out_ready. On pop, rptr increments.
- Latency: a pair pushed at edge N is visible on the outputs after edge N (one cycle, without bypass).
- count updates each edge: +1 on push only, -1 on pop only, unchanged on push+pop or no activity.
- Simultaneous push and pop are legal whenever not full and not empty.
- When full, in_ready=0 even if a pop happens the same cycle; there is no same-cycle refill.
- trace_done = eot_seen && empty. It is registered-derived and has no combinational path from inputs.
- Flush (synchronous, highest priority):
  - Clears wptr, rptr, count and eot_seen on that edge.
  - Any push or pop in the same cycle is ignored.
  - in_ready returns to 1 the next cycle.
- Reset asserted mid-operation: contents are discarded immediately, with the same values as reset.
- Order is strictly FIFO. No entry is ever dropped or duplicated.

Optional Feature:
- Macro IQ_BYPASS_EN.
- Defined:
  - When empty, in_valid=1, in_instr!=0 and out_ready=1, the input pair drives out_instr/out_pc combinationally and out_valid=1 in the same cycle.
  - The pair is consumed without being written; pointers and count are unchanged.
  - If out_ready=0, normal push occurs.
  - Zero-latency path when empty.
- Not defined: no input-to-output combinational path; minimum latency is one cycle.

Test Plan:
- Reset, then push 0x00500093@pc0, 0x00A00113@pc4, 0x002081B3@pc8 with out_ready=1 -> outputs appear in order, out_pc 0,4,8; count returns to 0; out_valid=0 afterwards.
- out_ready=0, push 8 pairs -> count=8, in_ready=0. A 9th in_valid is not accepted. Set out_ready=1 for one cycle -> count=7, head pc advances by 4.
- Push 12 pairs with out_ready toggling every cycle -> all 12 emerge in order across pointer wrap; count never exceeds 8.
- Push 2 pairs, then in_instr=0 -> in_ready=0 after that edge, count=2, trace_done=0. Drain both -> trace_done=1 the cycle after the last pop.
- Fill 5 entries, assert flush together with in_valid and out_ready -> next cycle count=0, out_valid=0, in_ready=1, nothing pushed.
- With IQ_BYPASS_EN, queue empty, out_ready=1, push 0x00500093 -> out_valid=1 the same cycle, count stays 0. Without the macro -> out_valid=1 the next cycle.
